alarm_tone_gen: RTL and testbench



---
 rtl/alarm_tone_gen.sv | 163 ++++++++++++++++
 tb/tb_alarm_tone_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: swept square-wave speaker drive with trigger/stop/timeout.
// Optional snooze state enabled by defining ALARM_SNOOZE_EN.
module alarm_tone_gen #(
    parameter int          TONE_W      = 28,
    parameter int          SWEEP_W     = 7,
    parameter int          SHIFT       = 6,
    parameter int          FAST_MSB    = 22,
    parameter int          SLOW_MSB    = 25,
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned SNOOZE_CYC  = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic       snooze,
    output logic       active,
    output logic       speaker
);

    localparam int DIV_W = 2 + SWEEP_W + SHIFT;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SOUND  = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;

    localparam logic [31:0] TO_LAST = TIMEOUT_CYC - 32'd1;
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

    localparam logic [TONE_W-1:0] TONE_ONE = {{(TONE_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [TONE_W-1:0]  tone_q, tone_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        to_q, to_d;
    logic               spk_q, spk_d;
    logic               act_q;
    logic               adv;

    logic [SWEEP_W-1:0] fast_f, slow_f;
    logic [SWEEP_W-1:0] fast_s, slow_s, steady_s, sweep;
    logic [DIV_W-1:0]   div;

`ifdef ALARM_SNOOZE_EN
    localparam logic [31:0] SNZ_LAST = SNOOZE_CYC - 32'd1;
    logic [31:0] snz_q, snz_d;
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    // Sweep field mirrors around the direction bit to form a triangle sweep.
    always_comb begin
        fast_f   = tone_q[FAST_MSB-1 -: SWEEP_W];
        slow_f   = tone_q[SLOW_MSB-1 -: SWEEP_W];
        fast_s   = tone_q[FAST_MSB] ? fast_f : ~fast_f;
        slow_s   = tone_q[SLOW_MSB] ? slow_f : ~slow_f;
        steady_s = {1'b1, {(SWEEP_W-1){1'b0}}};
        case (mode)
            2'b00:   sweep = steady_s;
            2'b01:   sweep = fast_s;
            2'b10:   sweep = slow_s;
            default: sweep = tone_q[TONE_W-1] ? slow_s : fast_s;
        endcase
        div = {2'b01, sweep, {SHIFT{1'b0}}};
    end

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        spk_d   = 1'b0;
        adv     = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_d   = snz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_SOUND;
                    tone_d  = '0;
                    cnt_d   = '0;
                    to_d    = '0;
                end
            end
            S_SOUND: begin
                adv  = 1'b1;
                to_d = to_q + 32'd1;
                if (stop) begin
                    state_d = S_IDLE;
                    adv     = 1'b0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    state_d = S_SNOOZE;
                    snz_d   = '0;
                    adv     = 1'b0;
                end
`endif
                else if (trigger) begin
                    to_d = '0;
                end else if (TO_EN && to_q == TO_LAST) begin
                    state_d = S_IDLE;
                    adv     = 1'b0;
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                snz_d = snz_q + 32'd1;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (trigger || snz_q == SNZ_LAST) begin
                    state_d = S_SOUND;
                    to_d    = '0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            tone_d = tone_q + TONE_ONE;
            if (cnt_q == '0) begin
                cnt_d = div;
                spk_d = ~spk_q;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
                spk_d = spk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tone_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            spk_q   <= 1'b0;
            act_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            spk_q   <= spk_d;
            act_q   <= (state_d != S_IDLE);
`ifdef ALARM_SNOOZE_EN
            snz_q   <= snz_d;
`endif
        end
    end

    assign active  = act_q;
    assign speaker = spk_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Scoreboard bench for alarm_tone_gen: reference model predicts active/speaker
// every edge, a monitor compares on the falling edge; directed checks on top.
module tb_alarm_tone_gen;

    localparam int P_TONE_W   = 12;
    localparam int P_SWEEP_W  = 4;
    localparam int P_SHIFT    = 2;
    localparam int P_FAST_MSB = 8;
    localparam int P_SLOW_MSB = 10;
    localparam int P_TIMEOUT  = 1000;
    localparam int P_SNOOZE   = 200;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       snooze = 1'b0;
    logic       active;
    logic       speaker;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];

    // Reference model: sounding time, absolute next-toggle time, timers.
    int m_state = 0;
    int m_st = 0;
    int m_nt = 0;
    int m_to = 0;
    int m_sc = 0;
    bit m_spk = 1'b0;

    alarm_tone_gen #(
        .TONE_W(P_TONE_W), .SWEEP_W(P_SWEEP_W), .SHIFT(P_SHIFT),
        .FAST_MSB(P_FAST_MSB), .SLOW_MSB(P_SLOW_MSB),
        .TIMEOUT_CYC(P_TIMEOUT), .SNOOZE_CYC(P_SNOOZE)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .stop(stop),
        .mode(mode), .snooze(snooze), .active(active), .speaker(speaker)
    );

    always #5 clk = ~clk;

    function automatic int half_len(input int st, input logic [1:0] md);
        int tone, fd, ff, sd, sf, fast, slow, sw, top;
        top  = (1 << P_SWEEP_W) - 1;
        tone = st % (1 << P_TONE_W);
        fd   = (tone >> P_FAST_MSB) & 1;
        ff   = (tone >> (P_FAST_MSB - P_SWEEP_W)) % (1 << P_SWEEP_W);
        sd   = (tone >> P_SLOW_MSB) & 1;
        sf   = (tone >> (P_SLOW_MSB - P_SWEEP_W)) % (1 << P_SWEEP_W);
        fast = fd ? ff : top - ff;
        slow = sd ? sf : top - sf;
        case (md)
            2'd0:    sw = 1 << (P_SWEEP_W - 1);
            2'd1:    sw = fast;
            2'd2:    sw = slow;
            default: sw = ((tone >> (P_TONE_W - 1)) & 1) ? slow : fast;
        endcase
        return (1 << (P_SWEEP_W + P_SHIFT)) + (sw << P_SHIFT) + 1;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_state = 0; m_st = 0; m_nt = 0;
            m_to = 0; m_sc = 0; m_spk = 1'b0;
        end else begin
            case (m_state)
                0: if (trigger) begin
                    m_state = 1; m_st = 0; m_nt = 0; m_to = 0;
                end
                1: begin
                    if (stop) begin
                        m_state = 0; m_spk = 1'b0;
                    end else if (SNZ_EN && snooze) begin
                        m_state = 2; m_sc = 0; m_spk = 1'b0;
                    end else if (!trigger && P_TIMEOUT != 0
                                 && m_to == P_TIMEOUT - 1) begin
                        m_state = 0; m_spk = 1'b0;
                    end else begin
                        m_to = trigger ? 0 : m_to + 1;
                        if (m_st == m_nt) begin
                            m_spk = !m_spk;
                            m_nt  = m_st + half_len(m_st, mode);
                        end
                        m_st++;
                    end
                end
                default: begin
                    if (stop) m_state = 0;
                    else if (trigger || m_sc == P_SNOOZE - 1) begin
                        m_state = 1; m_to = 0;
                    end else m_sc++;
                end
            endcase
        end
        exp_q.push_back({m_state != 0, m_spk});
    endtask

    task automatic step(input logic t, input logic s,
                        input logic z, input logic r);
        trigger = t; stop = s; snooze = z; reset = r;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_spk(input logic lvl, output int n);
        n = 0;
        while (speaker !== lvl && n < 1000) begin
            step(0, 0, 0, 0);
            n++;
        end
    endtask

    task automatic count_spk(input logic lvl, output int n);
        n = 0;
        while (speaker === lvl && n < 2000) begin
            n++;
            step(0, 0, 0, 0);
        end
    endtask

    initial begin : monitor
        logic [1:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({active, speaker} !== e) begin
                    errors++;
                    $display("FAIL cycle %0t: active/speaker got %b%b expected %b",
                             $time, active, speaker, e);
                end
            end
        end
    end

    initial begin : driver
        int n;
        repeat (3) step(0, 0, 0, 1);
        chk("reset_active", int'(active), 0);
        chk("reset_speaker", int'(speaker), 0);

        // fast sweep: first half 125 (sweep 15), next 97 (sweep 8)
        mode = 2'b01;
        step(1, 0, 0, 0);
        chk("active_after_trigger", int'(active), 1);
        wait_spk(1'b1, n);
        count_spk(1'b1, n);
        chk("fast_first_half", n, 125);
        count_spk(1'b0, n);
        chk("fast_second_half", n, 97);

        // steady mode half-period
        step(0, 1, 0, 0);
        chk("stop_idle", int'(active), 0);
        mode = 2'b00;
        step(1, 0, 0, 0);
        wait_spk(1'b1, n);
        count_spk(1'b1, n);
        chk("steady_half", n, 97);
        step(0, 1, 0, 0);

        // timeout without and with retrigger
        step(1, 0, 0, 0);
        n = 0;
        while (active === 1'b1 && n < 5000) begin
            n++;
            step(0, 0, 0, 0);
        end
        chk("timeout_len", n, 1000);
        chk("timeout_speaker", int'(speaker), 0);
        step(1, 0, 0, 0);
        n = 0;
        while (active === 1'b1 && n < 5000) begin
            n++;
            step(n == 500, 0, 0, 0);
        end
        chk("retrigger_len", n, 1500);

        // stop wins over trigger
        mode = 2'b10;
        step(1, 0, 0, 0);
        repeat (40) step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("stop_trig_active", int'(active), 0);
        chk("stop_trig_speaker", int'(speaker), 0);

        // reset with speaker high, then restart from tone 0
        mode = 2'b01;
        step(1, 0, 0, 0);
        wait_spk(1'b1, n);
        repeat (30) step(0, 0, 0, 0);
        chk("pre_reset_speaker", int'(speaker), 1);
        step(1, 0, 0, 1);
        chk("reset_mid_active", int'(active), 0);
        chk("reset_mid_speaker", int'(speaker), 0);
        step(1, 0, 0, 0);
        wait_spk(1'b1, n);
        count_spk(1'b1, n);
        chk("restart_first_half", n, 125);
        step(0, 1, 0, 0);

`ifdef ALARM_SNOOZE_EN
        step(1, 0, 0, 0);
        repeat (50) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < P_SNOOZE; i++) begin
            if (active === 1'b1 && speaker === 1'b0) n++;
            if (i < P_SNOOZE - 1) step(0, 0, 0, 0);
        end
        chk("snooze_silent", n, P_SNOOZE);
        wait_spk(1'b1, n);
        chk("snooze_resume", int'(speaker), 1);
        step(0, 0, 1, 0);
        repeat (20) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("snooze_stop", int'(active), 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(99) == 0) mode = 2'($urandom_range(3));
            step($urandom_range(149) == 0, $urandom_range(299) == 0,
                 $urandom_range(249) == 0, $urandom_range(1999) == 0);
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
